// File: rtl/ro_pkg.sv
// Shared definitions for the readout slot scheduler: FSM encoding and the
// Gray-code / one-hot helper functions.
package ro_pkg;

  localparam int RO_MAX_CH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } ro_state_t;

  function automatic logic [RO_MAX_CH-1:0] bin2gray(input logic [RO_MAX_CH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Highest set bit wins; callers only ever pass a one-hot vector.
  function automatic logic [4:0] onehot2idx(input logic [RO_MAX_CH-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < RO_MAX_CH; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ro_slot_gen.sv
// Frame counter with Gray conversion; exposes the next Gray value, the
// one-hot toggle vector for the current slot and the end-of-frame flag.
module ro_slot_gen
  import ro_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            advance,
  input  logic            clear,
  output logic [N_CH-1:0] cnt,
  output logic [N_CH-1:0] g_nxt,
  output logic [N_CH-1:0] t,
  output logic            wrap
);

  logic [N_CH-1:0] cnt_inc;
  logic [N_CH-1:0] g_cur;

  // Consecutive Gray codes differ in exactly one bit, so t is one-hot;
  // the all-ones -> zero wrap flips the MSB.
  assign cnt_inc = cnt + N_CH'(1);
  assign g_cur   = N_CH'(bin2gray(RO_MAX_CH'(cnt)));
  assign g_nxt   = N_CH'(bin2gray(RO_MAX_CH'(cnt_inc)));
  assign t       = g_cur ^ g_nxt;
  assign wrap    = &cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/ro_slot_scheduler.sv
// Time-division readout scheduler: one Gray-sequenced grant per cycle on a
// shared line. Optional per-channel masking is enabled by RO_CH_MASK_EN.
module ro_slot_scheduler
  import ro_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic [N_CH-1:0]  ch_in,
`ifdef RO_CH_MASK_EN
  input  logic [N_CH-1:0]  ch_mask,
`endif
  output logic [N_CH-1:0]  gray_out,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] ch_idx,
  output logic             data_out,
  output logic             data_valid,
  output logic             frame_done,
  output logic             busy
);

  ro_state_t        state;
  logic             advance_p0;
  logic             clear_p0;
  logic             slot_ok_p0;
  logic             wrap_p0;
  logic [N_CH-1:0]  cnt_p0;
  logic [N_CH-1:0]  g_nxt_p0;
  logic [N_CH-1:0]  t_p0;
  logic [IDX_W-1:0] t_idx_p0;

  assign advance_p0 = busy & en;
  // Idle always rests at count 0; the clear only guards against a stray value.
  assign clear_p0   = (state == IDLE) && (cnt_p0 != '0);
  assign t_idx_p0   = IDX_W'(onehot2idx(RO_MAX_CH'(t_p0)));

`ifdef RO_CH_MASK_EN
  assign slot_ok_p0 = ~|(t_p0 & ch_mask);
`else
  assign slot_ok_p0 = 1'b1;
`endif

  ro_slot_gen #(
    .N_CH(N_CH)
  ) u_slot_gen (
    .clk    (clk),
    .rstb   (rstb),
    .advance(advance_p0),
    .clear  (clear_p0),
    .cnt    (cnt_p0),
    .g_nxt  (g_nxt_p0),
    .t      (t_p0),
    .wrap   (wrap_p0)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= stop ? LAST : RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) state <= LAST;
        end
        LAST: begin
          if (advance_p0 && wrap_p0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: slot outputs registered on the advancing edge ----
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      gray_out   <= '0;
      grant      <= '0;
      ch_idx     <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      grant      <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      if (advance_p0) begin
        gray_out   <= g_nxt_p0;
        ch_idx     <= t_idx_p0;
        frame_done <= wrap_p0;
        if (slot_ok_p0) begin
          grant      <= t_p0;
          data_out   <= |(ch_in & t_p0);
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ro_slot_scheduler.sv
// Randomized self-checking bench for ro_slot_scheduler against a slot-level
// reference model (channel = trailing zeros of the next count).
module tb_ro_slot_scheduler;

  localparam int N  = 4;
  localparam int FR = 1 << N;

  logic         clk = 1'b0;
  logic         rstb;
  logic         en;
  logic         start;
  logic         stop;
  logic [N-1:0] ch_in;
`ifdef RO_CH_MASK_EN
  logic [N-1:0] ch_mask = '0;
`endif
  logic [N-1:0] gray_out;
  logic [N-1:0] grant;
  logic [1:0]   ch_idx;
  logic         data_out;
  logic         data_valid;
  logic         frame_done;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  int           m_mode;  // 0 idle, 1 running, 2 last frame
  int           m_cnt;
  logic [N-1:0] m_gray;
  logic [N-1:0] m_grant;
  int           m_idx;
  logic         m_data;
  logic         m_valid;
  logic         m_fd;

  int  vcount;
  int  fdcount;
  bit  seq_on;
  int  seq [16] = '{0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3};

  ro_slot_scheduler #(.N_CH(N)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .ch_in     (ch_in),
`ifdef RO_CH_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .gray_out  (gray_out),
    .grant     (grant),
    .ch_idx    (ch_idx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot_channel(input int c);
    int k;
    if (c == FR - 1) return N - 1;
    k = c + 1;
    for (int i = 0; i < N; i++) if (((k >> i) & 1) == 1) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_gray = '0; m_grant = '0;
    m_idx = 0; m_data = 1'b0; m_valid = 1'b0; m_fd = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit s, input bit p, input logic [N-1:0] c);
    int mode0;
    int ch;
    bit last_slot;
    if (!rstb) begin
      model_reset();
      return;
    end
    mode0 = m_mode;
    m_grant = '0; m_valid = 1'b0; m_fd = 1'b0;
    if (mode0 != 0 && e) begin
      ch        = slot_channel(m_cnt);
      last_slot = (m_cnt == FR - 1);
      m_grant   = N'(1) << ch;
      m_idx     = ch;
      m_data    = c[ch];
      m_valid   = 1'b1;
      m_fd      = last_slot;
      m_gray[ch] = ~m_gray[ch];
      m_cnt     = (m_cnt + 1) % FR;
      if (mode0 == 2 && last_slot) m_mode = 0;
    end
    if (mode0 == 0 && s) m_mode = p ? 2 : 1;
    else if (mode0 == 1 && p) m_mode = 2;
  endtask

  task automatic compare_all();
    chk("busy",       32'(busy),       32'(m_mode != 0));
    chk("grant",      32'(grant),      32'(m_grant));
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("gray_out",   32'(gray_out),   32'(m_gray));
    chk("ch_idx",     32'(ch_idx),     32'(m_idx));
    chk("data_out",   32'(data_out),   32'(m_data));
    if (data_valid) chk("onehot", 32'($onehot(grant)), 32'd1);
  endtask

  task automatic tick(input bit e, input bit s, input bit p, input logic [N-1:0] c);
    en = e; start = s; stop = p; ch_in = c;
    @(posedge clk);
    model_step(e, s, p, c);
    #1;
    compare_all();
    if (data_valid) begin
      if (seq_on) chk("seq", 32'(ch_idx), 32'(seq[vcount % 16]));
      vcount++;
    end
    if (frame_done) fdcount++;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [N-1:0] c);
    for (int n = 0; n < 60 && busy; n++) tick(1'b1, 1'b0, 1'b0, c);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic async_reset_pulse();
    #2 rstb = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 rstb = 1'b1;
  endtask

  initial begin
    logic [N-1:0] gsave;
    rstb = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; ch_in = '0;
    model_reset();
    seq_on = 1'b0;

    // reset held with start high, then idle without start
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 4'hF);
    rstb = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 4'hF);

    // two frames, stop issued after 20 cycles, constant ch_in
    vcount = 0; fdcount = 0; seq_on = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 4'b1010);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, 4'b1010);
    tick(1'b1, 1'b0, 1'b1, 4'b1010);
    drain("two_frame_idle", 4'b1010);
    seq_on = 1'b0;
    chk("two_frame_fd", 32'(fdcount), 32'd2);
    chk("two_frame_slots", 32'(vcount), 32'd32);
    tick(1'b1, 1'b0, 1'b0, 4'b1010);

    // en toggled 1,0,0,1 while running
    tick(1'b1, 1'b1, 1'b0, 4'h5);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 4'h5);
    tick(1'b1, 1'b0, 1'b0, 4'h5);
    gsave = gray_out;
    tick(1'b0, 1'b0, 1'b0, 4'h5);
    chk("en_hold_gray", 32'(gray_out), 32'(gsave));
    tick(1'b0, 1'b0, 1'b0, 4'h5);
    chk("en_hold_valid", 32'(data_valid), 32'd0);
    tick(1'b1, 1'b0, 1'b1, 4'h5);
    drain("en_idle", 4'h5);

    // start+stop together: one frame; a mid-frame start is ignored
    vcount = 0; fdcount = 0;
    tick(1'b1, 1'b1, 1'b1, 4'h3);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 4'h3);
    tick(1'b1, 1'b1, 1'b0, 4'h3);
    drain("one_frame_idle", 4'h3);
    chk("one_frame_slots", 32'(vcount), 32'd16);
    chk("one_frame_fd", 32'(fdcount), 32'd1);

    // asynchronous reset at slot 7, then restart from slot 0
    vcount = 0;
    tick(1'b1, 1'b1, 1'b0, 4'hC);
    for (int n = 0; n < 20 && vcount < 7; n++) tick(1'b1, 1'b0, 1'b0, 4'hC);
    async_reset_pulse();
    chk("rst_busy", 32'(busy), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 4'hC);
    tick(1'b1, 1'b0, 1'b0, 4'hC);
    chk("restart_gray", 32'(gray_out), 32'd1);
    chk("restart_idx", 32'(ch_idx), 32'd0);
    tick(1'b1, 1'b0, 1'b1, 4'hC);
    drain("restart_idle", 4'hC);

    // randomized control, enable, data and occasional reset
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 24) == 0,
           N'($urandom));
      if (($urandom % 400) == 0) async_reset_pulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_slot_scheduler.md
Name: ro_slot_scheduler

Overview:
- Time-division readout controller for a bank of N_CH readout tristate channels sharing one output line.
- A binary frame counter is converted to Gray code. Each cycle exactly one Gray bit toggles, and that bit index is the channel granted the shared line for that cycle.
- Output per slot: a one-hot grant to drive the channel tristates, plus a registered copy of the granted channel's comparator bit with a valid strobe.
- Sits between the global clock and the per-channel readout blocks; replaces free-running per-channel edge-detect enables with one sequenced, glitch-free schedule.

Parameters:
- N_CH, 4, number of readout channels; frame length is 2**N_CH cycles.
- IDX_W, $clog2(N_CH) (minimum 1), width of the channel index.

Ports:
- clk  in  1  global readout clock
- rstb  in  1  asynchronous active-low reset
- en  in  1  advance enable; low freezes the schedule
- start  in  1  pulse; begin frames
- stop  in  1  pulse; finish current frame, then idle
- ch_in  in  N_CH  comparator bits, one per channel
- gray_out  out  N_CH  current Gray count (registered)
- grant  out  N_CH  one-hot tristate enable, zero when idle
- ch_idx  out  IDX_W  index of granted channel
- data_out  out  1  sampled bit of granted channel
- data_valid  out  1  data_out/ch_idx valid this cycle
- frame_done  out  1  one-cycle pulse on frame wrap
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (rstb low, async): FSM=IDLE, cnt=0, gray_out=0, grant=0, ch_idx=0, data_out=0, data_valid=0, frame_done=0, busy=0.
- FSM states: IDLE, RUN, LAST.
  - IDLE -> RUN on start.
  - If start and stop arrive in the same IDLE cycle: IDLE -> LAST. This runs exactly one frame.
  - RUN -> LAST on stop.
  - LAST -> IDLE on the cycle the frame wraps.
  - start is ignored outside IDLE. stop is ignored in IDLE (unless coincident with start) and in LAST.
- Slot advance occurs when busy=1 (RUN or LAST) and en=1.
  - cnt increments, wrapping 2**N_CH-1 -> 0.
  - g_cur = cnt^(cnt>>1), g_nxt = gray(cnt+1 mod 2**N_CH). The toggle vector t = g_cur^g_nxt is always one-hot; the wrap toggles the MSB.
  - Registered at the same edge: grant<=t; ch_idx<=index(t); data_out<=ch_in[index(t)]; data_valid<=1; gray_out<=g_nxt.
  - Latency: ch_in is sampled at the advancing edge and is visible on data_out one cycle after the edge where the counter was at the old count.
- No advance (busy=0, or en=0): grant=0, data_valid=0, frame_done=0. cnt, gray_out and ch_idx hold.
- frame_done=1 on the advance where cnt goes 2**N_CH-1 -> 0. It is coincident with the final MSB grant.
- Slot count per frame: channel i gets 2**(N_CH-1-i) slots for i<N_CH-1; the MSB channel gets 2.
- LAST reaching wrap: the FSM enters IDLE and cnt rests at 0. The outputs of that final slot are still registered on that edge; grant returns to 0 on the next cycle.
- Mid-frame reset: everything clears immediately, asynchronously. No partial frame resumes.
- busy = (state != IDLE).

Optional Feature:
- Macro: RO_CH_MASK_EN.
- Defined: adds input ch_mask[N_CH]. A slot whose channel has ch_mask=1 still advances the counter but forces grant=0 and data_valid=0; data_out holds. frame_done is unaffected.
- Undefined: no ch_mask port; every slot is granted.

Decomposition:
- Package ro_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, LAST=2'd2), functions bin2gray and onehot2idx.
- One sub-module, ro_slot_gen: the counter, the Gray conversion and the toggle one-hot decode. It takes advance and clear inputs and outputs cnt, g_nxt, t and wrap.
- ro_slot_scheduler holds the FSM, the output registers and the mask logic.

Test Plan:
- Reset: drive rstb low for 3 cycles with start high -> all outputs 0, busy=0. Deassert rstb -> remains IDLE until a start pulse.
- N_CH=4, start pulse, en=1 held, stop after 20 cycles -> ch_idx sequence 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3 repeating.
  - frame_done after slot 16, then again after slot 32.
  - After the second frame_done: busy=0 and grant=0 on the following cycle.
- Set ch_in=4'b1010 constant -> data_out equals bit ch_idx each valid cycle, i.e. 0,1,0,0,0,1,0,1,...; grant is always one-hot while data_valid=1.
- en toggled 1,0,0,1 in RUN -> during en=0: grant=0, data_valid=0, gray_out held; the sequence resumes without a skipped slot.
- start and stop in the same IDLE cycle -> exactly 16 valid slots and one frame_done, then IDLE. A start issued mid-frame is ignored, with no restart of cnt.
- rstb pulsed low at slot 7 -> outputs clear asynchronously within the same cycle. A new start begins at ch_idx=0 with gray_out=4'b0001.
- With RO_CH_MASK_EN defined and ch_mask=4'b0001 -> no valid slot for channel 0; 8 valid slots per frame; frame_done still every 16 cycles.
